// File: rtl/snake_collision_checker.sv
// snake_collision_checker
// Reads the snake body RAM back after each head update and reports whether
// the new head has left the playfield or landed on its own body.

module snake_collision_checker #(
    parameter int ADDR_W = 11,
    parameter int X_MAX  = 160,
    parameter int Y_MAX  = 120
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        head_x,
    input  logic [6:0]        head_y,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [14:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              isDead
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALL = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Limits are widened by one bit so a limit equal to 2^width still works
    localparam logic [8:0] X_LIM = X_MAX[8:0];
    localparam logic [7:0] Y_LIM = Y_MAX[7:0];

    state_t              r_state;
    state_t              w_nextState;
    logic [7:0]          r_headX;
    logic [6:0]          r_headY;
    logic [ADDR_W-1:0]   r_length;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_cmpIdx;

    logic                w_wallHit;
    logic                w_lenLeOne;
    logic [ADDR_W-1:0]   w_lastIdx;
    logic                w_match;
    logic                w_lastCmp;

    assign w_wallHit  = ({1'b0, r_headX} >= X_LIM) || ({1'b0, r_headY} >= Y_LIM);
    assign w_lenLeOne = (r_length <= ADDR_W'(1));
    assign w_lastIdx  = r_length - ADDR_W'(1);
    assign w_match    = r_valid && (rd_data == {r_headX, r_headY});
    assign w_lastCmp  = r_valid && (r_cmpIdx == w_lastIdx);

    // State register; reset drops straight back to IDLE, aborting any scan
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: wall test first, then walk the body until a hit or the tail
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = WALL;
                end
            end
            WALL: begin
                if (w_wallHit || w_lenLeOne) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                if (w_match || w_lastCmp) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Handshake outputs are pure decodes of the state
    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Datapath: latch request, drive RAM address, track which entry rd_data holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_headX    <= '0;
            r_headY    <= '0;
            r_length   <= '0;
            r_valid    <= 1'b0;
            r_cmpIdx   <= '0;
            rd_address <= '0;
            isDead     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid    <= 1'b0;
                    rd_address <= '0;
                    if (start) begin
                        r_headX  <= head_x;
                        r_headY  <= head_y;
                        r_length <= length;
                        isDead   <= 1'b0;
                    end
                end
                WALL: begin
                    r_valid <= 1'b0;
                    if (w_wallHit) begin
                        isDead <= 1'b1;
                    end else if (!w_lenLeOne) begin
                        rd_address <= ADDR_W'(1);
                    end
                end
                SCAN: begin
                    // The address issued last edge returns data one cycle later
                    r_valid  <= 1'b1;
                    r_cmpIdx <= rd_address;
                    if (w_match) begin
                        isDead <= 1'b1;
                    end
                    if ((w_nextState == SCAN) && (rd_address < w_lastIdx)) begin
                        rd_address <= rd_address + ADDR_W'(1);
                    end
                end
                DONE: begin
                    r_valid    <= 1'b0;
                    rd_address <= '0;
                end
                default: begin
                    r_valid    <= 1'b0;
                    rd_address <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_collision_checker.sv
// tb_snake_collision_checker
// Directed bench with a behavioural body RAM, a reference model of the check
// and a scoreboard of expected {latency, isDead} per accepted start.

module tb_snake_collision_checker;

    localparam int ADDR_W = 11;
    localparam int LIMIT  = 5000;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        head_x;
    logic [6:0]        head_y;
    logic [ADDR_W-1:0] length;
    logic [ADDR_W-1:0] rd_address;
    logic [14:0]       rd_data;
    logic              busy;
    logic              done;
    logic              isDead;

    typedef struct {
        int lat;
        bit dead;
    } expT;

    expT         sb[$];
    logic [14:0] ram [0:(1<<ADDR_W)-1];
    int          checks;
    int          errors;
    int          lastMaxAddr;
    int          addrLog[$];

    snake_collision_checker #(
        .ADDR_W(ADDR_W),
        .X_MAX (160),
        .Y_MAX (120)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .rd_address(rd_address),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .isDead    (isDead)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read body RAM: address registered at the edge, data valid after it
    always @(posedge clk) begin
        rd_data <= ram[rd_address];
    end

    // Single comparison point: counts and reports every check
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model of one collision check against the bench RAM
    function automatic expT modelCheck(input logic [7:0] hx, input logic [6:0] hy,
                                       input int len);
        expT r;
        r.lat  = len + 1;
        r.dead = 1'b0;
        if (hx >= 8'd160 || hy >= 7'd120) begin
            r.lat  = 1;
            r.dead = 1'b1;
        end else if (len <= 1) begin
            r.lat = 1;
        end else begin
            for (int k = 1; k < len; k++) begin
                if (ram[k] == {hx, hy}) begin
                    r.lat  = k + 2;
                    r.dead = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Drive one start pulse (optionally left high) and queue its expected result
    task automatic applyStimulus(input logic [7:0] hx, input logic [6:0] hy,
                                 input int len, input bit hold);
        @(negedge clk);
        head_x = hx;
        head_y = hy;
        length = ADDR_W'(len);
        start  = 1'b1;
        sb.push_back(modelCheck(hx, hy, len));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Called one step after the accept edge: wait for done, compare against scoreboard
    task automatic checkOutput(input string tag);
        expT e;
        int  lat;
        int  busyCnt;
        if (sb.size() == 0) begin
            chk({tag, "_sbEmpty"}, 32'd0, 32'd1);
            return;
        end
        e           = sb.pop_front();
        lat         = 0;
        busyCnt     = (busy === 1'b1) ? 1 : 0;
        lastMaxAddr = int'(rd_address);
        addrLog.delete();
        while (done !== 1'b1 && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) busyCnt++;
            if (int'(rd_address) > lastMaxAddr) lastMaxAddr = int'(rd_address);
            addrLog.push_back(int'(rd_address));
        end
        chk({tag, "_timeout"}, (lat < LIMIT) ? 32'd1 : 32'd0, 32'd1);
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_isDead"}, isDead, e.dead);
        chk({tag, "_busyCycles"}, busyCnt, e.lat + 1);
        @(posedge clk);
        #1;
        chk({tag, "_postBusy"}, busy, 1'b0);
        chk({tag, "_postDone"}, done, 1'b0);
        chk({tag, "_postIsDead"}, isDead, e.dead);
        chk({tag, "_postAddr"}, rd_address, 0);
    endtask

    initial begin
        int waitCnt;
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 15'h7FFF;
        rst    = 1'b0;
        start  = 1'b0;
        head_x = '0;
        head_y = '0;
        length = '0;
        repeat (3) @(negedge clk);
        chk("resetBusy", busy, 1'b0);
        chk("resetDone", done, 1'b0);
        chk("resetIsDead", isDead, 1'b0);
        chk("resetAddr", rd_address, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idleBusy", busy, 1'b0);

        $display("[TB] wall hit on x");
        applyStimulus(8'd160, 7'd10, 5, 1'b0);
        checkOutput("wallX");
        chk("wallX_noReads", lastMaxAddr, 0);

        $display("[TB] full scan, no hit");
        ram[1] = {8'd59, 7'd60};
        ram[2] = {8'd58, 7'd60};
        ram[3] = {8'd57, 7'd60};
        applyStimulus(8'd60, 7'd60, 4, 1'b0);
        checkOutput("scan4");
        chk("scan4_addr1", addrLog[0], 1);
        chk("scan4_addr2", addrLog[1], 2);
        chk("scan4_addr3", addrLog[2], 3);
        chk("scan4_maxAddr", lastMaxAddr, 3);

        $display("[TB] early hit at index 2");
        ram[2] = {8'd60, 7'd60};
        ram[4] = {8'd56, 7'd60};
        ram[5] = {8'd55, 7'd60};
        applyStimulus(8'd60, 7'd60, 6, 1'b0);
        checkOutput("hit2");
        chk("hit2_addrBelow5", (lastMaxAddr < 5) ? 32'd1 : 32'd0, 32'd1);

        $display("[TB] short snakes and boundaries");
        applyStimulus(8'd60, 7'd60, 1, 1'b0);
        checkOutput("len1");
        applyStimulus(8'd10, 7'd120, 3, 1'b0);
        checkOutput("wallY");
        applyStimulus(8'd20, 7'd20, 0, 1'b0);
        checkOutput("len0");
        ram[1] = {8'd158, 7'd119};
        applyStimulus(8'd159, 7'd119, 2, 1'b0);
        checkOutput("edgeInBounds");

        $display("[TB] start held high, head changed mid-scan");
        for (int i = 1; i <= 9; i++) ram[i] = {8'(40 + i), 7'd60};
        ram[4] = {8'd5, 7'd60};
        applyStimulus(8'd60, 7'd60, 10, 1'b1);
        @(negedge clk);
        head_x = 8'd5;
        checkOutput("held1");
        sb.push_back(modelCheck(8'd5, 7'd60, 10));
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("held2");

        $display("[TB] longest snake, hit on the tail");
        ram[(1 << ADDR_W) - 2] = {8'd1, 7'd1};
        applyStimulus(8'd1, 7'd1, (1 << ADDR_W) - 1, 1'b0);
        checkOutput("maxLen");
        chk("maxLen_maxAddr", lastMaxAddr, (1 << ADDR_W) - 2);

        $display("[TB] reset during scan");
        applyStimulus(8'd70, 7'd70, 10, 1'b0);
        waitCnt = 0;
        while (rd_address !== ADDR_W'(3) && waitCnt < 50) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        chk("midReset_reachIdx3", (waitCnt < 50) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midReset_busy", busy, 1'b0);
        chk("midReset_done", done, 1'b0);
        chk("midReset_isDead", isDead, 1'b0);
        chk("midReset_addr", rd_address, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(8'd70, 7'd70, 10, 1'b0);
        checkOutput("afterReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
